// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stall/flush control,
// mul/div occupancy FSM and a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        useRtD,
    input  logic        branchD,
    input  logic        branch_takenD,
    input  logic        jumpD,
    input  logic [4:0]  writeRegE,
    input  logic [4:0]  writeRegM,
    input  logic        Regfile_weE,
    input  logic        memToRegE,
    input  logic        memToRegM,
    input  logic        md_startE,
    input  logic        dmem_stall,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    // state   | meaning
    // RUN     | no mul/div op in flight
    // MD_WAIT | mul/div op occupying EX, md_cnt counting down to the done cycle
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LP_MD_INIT = 8'(MD_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_md_cnt;
    logic [7:0]  w_md_cnt_nxt;
    logic [31:0] r_stall_cycles;

    logic w_match_e;
    logic w_match_m;
    logic w_load_use;
    logic w_br_haz;
    logic w_md_hold;

    always_comb begin
        w_match_e  = Regfile_weE && (writeRegE != 5'd0) &&
                     ((writeRegE == rsD) || (useRtD && (writeRegE == rtD)));
        w_match_m  = memToRegM && (writeRegM != 5'd0) &&
                     ((writeRegM == rsD) || (useRtD && (writeRegM == rtD)));
        w_load_use = memToRegE && w_match_e;
        w_br_haz   = branchD && (w_match_e || w_match_m);
        w_md_hold  = ((r_state == RUN) && md_startE) ||
                     ((r_state == MD_WAIT) && (r_md_cnt != 8'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // The functional unit keeps counting through memory waits; only the exit waits.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        md_done      = 1'b0;
        case (r_state)
            RUN: begin
                if (md_startE && !dmem_stall) begin
                    w_state_nxt  = MD_WAIT;
                    w_md_cnt_nxt = LP_MD_INIT;
                end
            end
            MD_WAIT: begin
                if (r_md_cnt != 8'd0) begin
                    w_md_cnt_nxt = r_md_cnt - 8'd1;
                end else if (!dmem_stall) begin
                    md_done     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (dmem_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (w_md_hold) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (w_load_use || w_br_haz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (branch_takenD || jumpD) begin
            flushD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
        end else if (stallD && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign md_busy      = (r_state == MD_WAIT);
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard sequences plus random traffic,
// checked each cycle against a priority-rule reference model.
module tb_pipeline_ctrl;

    localparam int unsigned LAT = 4;

    typedef struct packed {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic       useRtD;
        logic       branchD;
        logic       branch_takenD;
        logic       jumpD;
        logic [4:0] writeRegE;
        logic [4:0] writeRegM;
        logic       weE;
        logic       memToRegE;
        logic       memToRegM;
        logic       md_startE;
        logic       dmem_stall;
    } stim_t;

    // ctl = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, md_busy, md_done}
    typedef struct packed {
        logic [8:0]  ctl;
        logic [31:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rsD = '0, rtD = '0, writeRegE = '0, writeRegM = '0;
    logic        useRtD = 0, branchD = 0, branch_takenD = 0, jumpD = 0;
    logic        Regfile_weE = 0, memToRegE = 0, memToRegM = 0, md_startE = 0, dmem_stall = 0;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushM, md_busy, md_done;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    // reference model state: whether an op is in flight and how many hold cycles remain
    bit      m_inflight;
    int      m_left;
    longint  m_stalls;

    pipeline_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRtD(useRtD),
        .branchD(branchD), .branch_takenD(branch_takenD), .jumpD(jumpD),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .Regfile_weE(Regfile_weE),
        .memToRegE(memToRegE), .memToRegM(memToRegM), .md_startE(md_startE),
        .dmem_stall(dmem_stall), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic bit reads(input stim_t s, input logic [4:0] r);
        return (r != 5'd0) && ((r == s.rsD) || (s.useRtD && (r == s.rtD)));
    endfunction

    function automatic exp_t model_out(input stim_t s);
        exp_t e;
        bit hz_e, hz_m, hold, haz;
        hz_e = s.weE && reads(s, s.writeRegE);
        hz_m = s.memToRegM && reads(s, s.writeRegM);
        hold = m_inflight ? (m_left > 0) : s.md_startE;
        haz  = (s.memToRegE && hz_e) || (s.branchD && (hz_e || hz_m));
        e.ctl = '0;
        if (s.dmem_stall)                    e.ctl[8:5] = 4'b1111;
        else if (hold)                       begin e.ctl[8:6] = 3'b111; e.ctl[2] = 1'b1; end
        else if (haz)                        begin e.ctl[8:7] = 2'b11;  e.ctl[3] = 1'b1; end
        else if (s.branch_takenD || s.jumpD) e.ctl[4] = 1'b1;
        e.ctl[1] = m_inflight;
        e.ctl[0] = m_inflight && (m_left == 0) && !s.dmem_stall;
        e.sc = (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rsD = s.rsD; rtD = s.rtD; useRtD = s.useRtD; branchD = s.branchD;
        branch_takenD = s.branch_takenD; jumpD = s.jumpD; writeRegE = s.writeRegE;
        writeRegM = s.writeRegM; Regfile_weE = s.weE; memToRegE = s.memToRegE;
        memToRegM = s.memToRegM; md_startE = s.md_startE; dmem_stall = s.dmem_stall;
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        apply(s);
        e = model_out(s);
        q.push_back(e);
        if (e.ctl[7]) m_stalls++;
        if (!m_inflight) begin
            if (s.md_startE && !s.dmem_stall) begin
                m_inflight = 1'b1;
                m_left     = LAT - 1;
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (!s.dmem_stall) begin
            m_inflight = 1'b0;
        end
    endtask

    task automatic do_reset();
        stim_t z = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(z);
        #1;
        n_cmp++;
        if (md_busy !== 1'b0 || stall_cycles !== 32'd0 || md_done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b done=%b sc=%0d, required busy=0 done=0 sc=0",
                     md_busy, md_done, stall_cycles);
        end
        m_inflight = 1'b0;
        m_left     = 0;
        m_stalls   = 0;
        q.push_back(model_out(z));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if ({stallF, stallD, stallE, stallM, flushD, flushE, flushM, md_busy, md_done} !== e.ctl) begin
                    n_bad++;
                    $display("FAIL ctl @%0t: got %b, required %b", $time,
                             {stallF, stallD, stallE, stallM, flushD, flushE, flushM, md_busy, md_done}, e.ctl);
                end
                n_cmp++;
                if (stall_cycles !== e.sc) begin
                    n_bad++;
                    $display("FAIL stall_cycles @%0t: got %0d, required %0d", $time, stall_cycles, e.sc);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        stim_t z;
        int wait_cnt;
        z = '0;
        m_inflight = 1'b0;
        m_left     = 0;
        m_stalls   = 0;

        do_reset();
        cyc(z); cyc(z);

        // load-use on $8
        s = z; s.memToRegE = 1; s.weE = 1; s.writeRegE = 5'd8; s.rsD = 5'd8;
        cyc(s); cyc(z);

        // branch behind a load to $9: load_use, then the MEM-stage match, then resolve taken
        s = z; s.branchD = 1; s.rsD = 5'd9; s.memToRegE = 1; s.weE = 1; s.writeRegE = 5'd9;
        cyc(s);
        s = z; s.branchD = 1; s.rsD = 5'd9; s.memToRegM = 1; s.writeRegM = 5'd9;
        cyc(s);
        s = z; s.branchD = 1; s.rsD = 5'd9; s.branch_takenD = 1;
        cyc(s);
        // stalled taken branch must not flush
        s = z; s.branchD = 1; s.branch_takenD = 1; s.rtD = 5'd3; s.useRtD = 1;
        s.weE = 1; s.writeRegE = 5'd3;
        cyc(s);

        // $0 destination never hazards
        s = z; s.memToRegE = 1; s.weE = 1; s.writeRegE = 5'd0; s.rsD = 5'd0;
        cyc(s);

        s = z; s.jumpD = 1;
        cyc(s); cyc(z);

        // mul/div held for its full occupancy
        s = z; s.md_startE = 1;
        for (int i = 0; i < LAT + 1; i++) cyc(s);
        cyc(z);

        // 3-cycle memory wait arriving when md_cnt is 1
        for (int i = 0; i < 7; i++) begin
            s = z; s.md_startE = 1; s.dmem_stall = (i >= 3 && i <= 5);
            cyc(s);
        end
        cyc(z);

        // start blocked by a memory wait, then accepted
        s = z; s.md_startE = 1; s.dmem_stall = 1;
        cyc(s);
        s.dmem_stall = 0;
        for (int i = 0; i < LAT + 1; i++) cyc(s);

        // reset in the middle of an op
        s = z; s.md_startE = 1;
        cyc(s); cyc(s);
        do_reset();
        cyc(z); cyc(z);

        for (int i = 0; i < 3000; i++) begin
            s.rsD           = 5'($urandom_range(0, 3));
            s.rtD           = 5'($urandom_range(0, 3));
            s.useRtD        = 1'($urandom_range(0, 1));
            s.branchD       = ($urandom_range(0, 3) == 0);
            s.branch_takenD = s.branchD && ($urandom_range(0, 1) == 1);
            s.jumpD         = !s.branchD && ($urandom_range(0, 7) == 0);
            s.writeRegE     = 5'($urandom_range(0, 3));
            s.writeRegM     = 5'($urandom_range(0, 3));
            s.weE           = 1'($urandom_range(0, 1));
            s.memToRegE     = s.weE && ($urandom_range(0, 1) == 1);
            s.memToRegM     = ($urandom_range(0, 2) == 0);
            s.md_startE     = ($urandom_range(0, 9) == 0) || (m_inflight && $urandom_range(0, 1) == 1);
            s.dmem_stall    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else                             cyc(s);
        end
        cyc(z);

        wait_cnt = 0;
        while (q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage pipeline. It drives the stall and flush controls of the IF/ID, ID/EX and EX/MEM stage registers, covering these cases:
- load-use hazards
- branch-in-ID operand hazards
- taken branch/jump squashes
- data-memory wait states
- a multi-cycle multiply/divide occupancy state machine

It sits beside the decode stage and sees register specifiers from ID, EX and MEM. A saturating stall-cycle counter is kept for performance monitoring.

## Interface
- MD_LATENCY, 32, cycles a mul/div op needs in EX; legal range 2..255.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rsD, rtD  in  5 each  source register specifiers of the instruction in ID.
- useRtD  in  1  the instruction in ID reads rt as a source.
- branchD  in  1  the instruction in ID is a conditional branch; operands are compared in ID.
- branch_takenD  in  1  branch in ID resolves taken.
- jumpD  in  1  jump in ID.
- writeRegE, writeRegM  in  5 each  destination register of the instructions in EX and MEM.
- Regfile_weE, memToRegE  in  1 each  EX-stage instruction writes the register file / is a load.
- memToRegM  in  1  MEM-stage instruction is a load.
- md_startE  in  1  a mul/div op occupies EX.
- dmem_stall  in  1  data memory is not ready this cycle.
- stallF, stallD, stallE, stallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers respectively.
- flushD, flushE, flushM  out  1 each  load a bubble into IF/ID, ID/EX and EX/MEM respectively.
- md_busy  out  1  FSM is in MD_WAIT.
- md_done  out  1  one-cycle pulse when the mul/div op leaves EX.
- stall_cycles  out  32  count of cycles with stallD=1; saturates at 0xFFFFFFFF.

## Operation
FSM states and counter:
- States: RUN, MD_WAIT.
- md_cnt is 8 bits.

Combinational hazard terms:
- matchE = Regfile_weE & (writeRegE!=0) & (writeRegE==rsD | (useRtD & writeRegE==rtD)).
- matchM = memToRegM & (writeRegM!=0) & (writeRegM==rsD | (useRtD & writeRegM==rtD)).
- load_use = memToRegE & matchE.
- br_haz = branchD & (matchE | matchM).
- md_hold = (RUN & md_startE) | (MD_WAIT & md_cnt!=0).

Output priority, highest first. Outputs not listed in a row are 0.
1. dmem_stall=1: stallF, stallD, stallE and stallM are all 1. No flushes.
2. md_hold: stallF, stallD and stallE are 1; flushM=1, so bubbles go to MEM.
3. load_use | br_haz: stallF and stallD are 1; flushE=1.
4. (branch_takenD | jumpD): flushD=1.

FSM transitions:
- RUN & md_startE & !dmem_stall: go to MD_WAIT, md_cnt <= MD_LATENCY-1.
- RUN & md_startE & dmem_stall: stay in RUN. md_startE is re-sampled when dmem_stall drops.
- MD_WAIT & md_cnt!=0: md_cnt decrements every cycle, including cycles with dmem_stall=1, because the functional unit keeps running.
- MD_WAIT & md_cnt==0 & !dmem_stall: md_done=1; next state RUN.
- MD_WAIT & md_cnt==0 & dmem_stall: stay in MD_WAIT with md_cnt at 0; md_done stays 0.
- md_startE is ignored while in MD_WAIT. The held op keeps asserting it, and that must not retrigger the FSM.

Other rules:
- md_busy = (state==MD_WAIT).
- stall_cycles increments on every cycle where stallD=1, until it saturates.

## Timing
- All stall/flush outputs and md_done are combinational from the current state and inputs; they take effect in the same cycle.
- On reset (rst low): state is RUN, md_cnt=0, stall_cycles=0, and md_busy=0. With the inputs idle, every stall, flush and md_done output is 0.
- Reset asserted mid-MD_WAIT: the FSM returns to RUN immediately and asynchronously. No md_done pulse is produced.
- Mul/div stall length:
  - With no dmem_stall, stallD is high for exactly MD_LATENCY cycles: the start cycle plus MD_LATENCY-1 MD_WAIT cycles.
  - Then one done cycle with no stall.
  - The op therefore occupies EX for MD_LATENCY+1 cycles.
- Load-use stall: 1 cycle. The load then moves to MEM and the forwarding path covers the dependence.
- Branch hazard stall: 1 cycle for an EX-stage ALU producer. For an EX-stage load producer it is 2 cycles: load_use first, then matchM.
- A taken branch that is also stalled is not flushed until the stall clears.

## Test plan
- Load-use: a load to $8 in EX (memToRegE=1, Regfile_weE=1, writeRegE=8) with rsD=8 → stallF=stallD=flushE=1 for 1 cycle; stall_cycles=1.
- Branch after load: branchD=1, rsD=9, and a load to $9 in EX, which then advances to MEM → 2 cycles of stallD; no flushD until the third cycle, when branch_takenD=1 gives flushD=1.
- Mul/div with MD_LATENCY=4: md_startE held high → stallE=1 for 4 cycles, flushM=1 in each of them; md_busy high for 4 cycles; md_done=1 on cycle 5; state returns to RUN.
- dmem_stall pulse of 3 cycles while md_cnt=1 → md_cnt reaches 0 and holds; md_done is delayed until dmem_stall drops; stallM=1 throughout the dmem_stall window.
- Register $0 as destination (writeRegE=0, load, rsD=0) → no stall.
- Jump with no hazard → flushD=1 only.
- Reset pulled low for 1 cycle in the middle of MD_WAIT → md_busy=0 immediately; stall_cycles=0; no md_done.
